// File: rtl/conv_tile_controller.sv
// -----------------------------------------------------------------------------
// conv_tile_controller
//   Tiled convolution loop controller for the MAC datapath. The feature map is
//   split along x into NB_TILES column tiles; each tile is requested, loaded
//   and then swept with the loop nest x, y, ch_in, ch_out, k_v, k_h
//   (outer -> inner). Two copies of the loop nest run one cycle apart: the
//   read nest drives buffer addresses, the compute nest tracks what the MAC is
//   working on.
//
// Ports
//   clk, arst_n_in          clock, asynchronous active-low reset
//   start                   begin a layer (only looked at in IDLE)
//   running                 high outside IDLE
//   tile_req, tile_idx      tile load request / current tile
//   data_ready              tile loaded (only looked at in LOAD)
//   int_mem_re              internal buffer read strobe
//   ky/kx/inch/outch/y/x_out read address counters (x_out is tile-local)
//   mac_valid, mac_accumulate_internal, mac_accumulate_with_0   MAC controls
//   mem_re, mem_read_addr   partial-sum read
//   mem_we, mem_write_addr  partial-sum write (registered)
//   output_valid/ready, output_x/y/ch   finished output pixel handshake
//   tile_done, fsm_done     single-cycle completion pulses
// -----------------------------------------------------------------------------

// Six-deep wrapping loop nest; a counter steps when all inner counters are at
// their last value. clear has priority over en.
module conv_loop_nest #(
    parameter int unsigned K  = 3,
    parameter int unsigned CI = 64,
    parameter int unsigned CO = 64,
    parameter int unsigned H  = 1024,
    parameter int unsigned TW = 512
) (
    input  logic        clk,
    input  logic        arst_n_in,
    input  logic        clear,
    input  logic        en,
    output logic [31:0] kh,
    output logic [31:0] kv,
    output logic [31:0] cho,
    output logic [31:0] chi,
    output logic [31:0] y,
    output logic [31:0] x,
    output logic        last_all
);
    logic l_kh, l_kv, l_cho, l_chi, l_y, l_x;

    always_comb begin
        l_kh     = (kh  == 32'(K  - 1));
        l_kv     = (kv  == 32'(K  - 1));
        l_cho    = (cho == 32'(CO - 1));
        l_chi    = (chi == 32'(CI - 1));
        l_y      = (y   == 32'(H  - 1));
        l_x      = (x   == 32'(TW - 1));
        last_all = l_kh && l_kv && l_cho && l_chi && l_y && l_x;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            kh  <= '0;
            kv  <= '0;
            cho <= '0;
            chi <= '0;
            y   <= '0;
            x   <= '0;
        end else if (clear) begin
            kh  <= '0;
            kv  <= '0;
            cho <= '0;
            chi <= '0;
            y   <= '0;
            x   <= '0;
        end else if (en) begin
            kh <= l_kh ? '0 : kh + 32'd1;
            if (l_kh)
                kv <= l_kv ? '0 : kv + 32'd1;
            if (l_kh && l_kv)
                cho <= l_cho ? '0 : cho + 32'd1;
            if (l_kh && l_kv && l_cho)
                chi <= l_chi ? '0 : chi + 32'd1;
            if (l_kh && l_kv && l_cho && l_chi)
                y <= l_y ? '0 : y + 32'd1;
            if (l_kh && l_kv && l_cho && l_chi && l_y)
                x <= l_x ? '0 : x + 32'd1;
        end
    end
endmodule

module conv_tile_controller #(
    parameter int unsigned LOG2_OF_MEM_HEIGHT = 20,
    parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
    parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
    parameter int unsigned INPUT_NB_CHANNELS  = 64,
    parameter int unsigned OUTPUT_NB_CHANNELS = 64,
    parameter int unsigned KERNEL_SIZE        = 3,
    parameter int unsigned NB_TILES           = 2
) (
    input  logic                          clk,
    input  logic                          arst_n_in,
    input  logic                          start,
    output logic                          running,
    output logic                          tile_req,
    output logic [31:0]                   tile_idx,
    input  logic                          data_ready,
    output logic                          int_mem_re,
    output logic [31:0]                   ky_out,
    output logic [31:0]                   kx_out,
    output logic [31:0]                   inch_out,
    output logic [31:0]                   outch_out,
    output logic [31:0]                   y_out,
    output logic [31:0]                   x_out,
    output logic                          mac_valid,
    output logic                          mac_accumulate_internal,
    output logic                          mac_accumulate_with_0,
    output logic                          mem_re,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_read_addr,
    output logic                          mem_we,
    output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_write_addr,
    output logic                          output_valid,
    input  logic                          output_ready,
    output logic [31:0]                   output_x,
    output logic [31:0]                   output_y,
    output logic [31:0]                   output_ch,
    output logic                          tile_done,
    output logic                          fsm_done
);
    localparam int unsigned TILE_W = FEATURE_MAP_WIDTH / NB_TILES;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        MAC,
        DRAIN
    } state_t;

    state_t state, state_n;

    logic        stall;
    logic        cnt_clear;
    logic        r_last_all, r_done;
    logic [31:0] c_kh, c_kv, c_cho, c_chi, c_y, c_x;
    logic        c_last_all, c_first_win, c_last_win, c_last_chi;
    logic        out_evt, wr_evt;

    assign stall = output_valid && !output_ready;

    conv_loop_nest #(
        .K  (KERNEL_SIZE),
        .CI (INPUT_NB_CHANNELS),
        .CO (OUTPUT_NB_CHANNELS),
        .H  (FEATURE_MAP_HEIGHT),
        .TW (TILE_W)
    ) u_read_nest (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .clear    (cnt_clear),
        .en       (int_mem_re),
        .kh       (kx_out),
        .kv       (ky_out),
        .cho      (outch_out),
        .chi      (inch_out),
        .y        (y_out),
        .x        (x_out),
        .last_all (r_last_all)
    );

    conv_loop_nest #(
        .K  (KERNEL_SIZE),
        .CI (INPUT_NB_CHANNELS),
        .CO (OUTPUT_NB_CHANNELS),
        .H  (FEATURE_MAP_HEIGHT),
        .TW (TILE_W)
    ) u_compute_nest (
        .clk      (clk),
        .arst_n_in(arst_n_in),
        .clear    (cnt_clear),
        .en       (mac_valid),
        .kh       (c_kh),
        .kv       (c_kv),
        .cho      (c_cho),
        .chi      (c_chi),
        .y        (c_y),
        .x        (c_x),
        .last_all (c_last_all)
    );

    always_comb begin
        c_first_win             = (c_kh == '0) && (c_kv == '0);
        c_last_win              = (c_kh == 32'(KERNEL_SIZE - 1)) &&
                                  (c_kv == 32'(KERNEL_SIZE - 1));
        c_last_chi              = (c_chi == 32'(INPUT_NB_CHANNELS - 1));
        mac_accumulate_internal = !c_first_win;
        mac_accumulate_with_0   = c_first_win && (c_chi == '0);
        mem_re                  = mac_valid && c_first_win && (c_chi != '0);
        mem_read_addr           = c_cho[LOG2_OF_MEM_HEIGHT-1:0];
        out_evt                 = mac_valid && c_last_win && c_last_chi;
        wr_evt                  = mac_valid && c_last_win && !c_last_chi;
    end

    always_comb begin
        state_n    = state;
        running    = (state != IDLE);
        tile_req   = 1'b0;
        int_mem_re = 1'b0;
        mac_valid  = 1'b0;
        tile_done  = 1'b0;
        fsm_done   = 1'b0;
        cnt_clear  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = LOAD;
                    cnt_clear = 1'b1;
                end
            end
            LOAD: begin
                tile_req = 1'b1;
                if (data_ready)
                    state_n = FETCH;
            end
            FETCH: begin
                // Primes the one-cycle buffer latency: read nest runs one ahead.
                int_mem_re = 1'b1;
                state_n    = MAC;
            end
            MAC: begin
                if (!stall) begin
                    mac_valid  = 1'b1;
                    int_mem_re = !r_done;
                    if (c_last_all)
                        state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (!output_valid) begin
                    tile_done = 1'b1;
                    if (tile_idx < 32'(NB_TILES - 1)) begin
                        state_n   = LOAD;
                        cnt_clear = 1'b1;
                    end else begin
                        fsm_done = 1'b1;
                        state_n  = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state    <= IDLE;
            tile_idx <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start)
                tile_idx <= '0;
            else if (state == DRAIN && !output_valid)
                tile_idx <= (tile_idx < 32'(NB_TILES - 1)) ? tile_idx + 32'd1 : '0;
        end
    end

    // The read nest wraps to zero after its final read; this flag keeps it
    // from issuing a second sweep while the compute nest finishes.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in)
            r_done <= 1'b0;
        else if (cnt_clear)
            r_done <= 1'b0;
        else if (int_mem_re && r_last_all)
            r_done <= 1'b1;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            output_valid   <= 1'b0;
            output_x       <= '0;
            output_y       <= '0;
            output_ch      <= '0;
            mem_we         <= 1'b0;
            mem_write_addr <= '0;
        end else begin
            mem_we <= wr_evt;
            if (wr_evt)
                mem_write_addr <= c_cho[LOG2_OF_MEM_HEIGHT-1:0];
            if (out_evt) begin
                output_valid <= 1'b1;
                output_x     <= tile_idx * 32'(TILE_W) + c_x;
                output_y     <= c_y;
                output_ch    <= c_cho;
            end else if (output_valid && output_ready) begin
                output_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_conv_tile_controller.sv
// -----------------------------------------------------------------------------
// tb_conv_tile_controller
//   Directed bench for conv_tile_controller at W=4, H=2, CI=2, CO=2, K=3,
//   NB_TILES=2. A negedge monitor keeps an index-based model: the n-th MAC,
//   n-th buffer read, n-th psum write and n-th accepted output of a tile have
//   loop coordinates obtained by decomposing n with the loop bounds.
// -----------------------------------------------------------------------------
module tb_conv_tile_controller;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CI = 2;
    localparam int CO = 2;
    localparam int K  = 3;
    localparam int NB = 2;
    localparam int TW = W / NB;
    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          arst_n_in = 1'b0;
    logic          start = 1'b0;
    logic          data_ready = 1'b0;
    logic          output_ready = 1'b1;
    logic          running, tile_req, int_mem_re, mac_valid;
    logic          mac_accumulate_internal, mac_accumulate_with_0;
    logic          mem_re, mem_we, output_valid, tile_done, fsm_done;
    logic [31:0]   tile_idx, ky_out, kx_out, inch_out, outch_out, y_out, x_out;
    logic [31:0]   output_x, output_y, output_ch;
    logic [AW-1:0] mem_read_addr, mem_write_addr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    conv_tile_controller #(
        .LOG2_OF_MEM_HEIGHT(AW),
        .FEATURE_MAP_WIDTH (W),
        .FEATURE_MAP_HEIGHT(H),
        .INPUT_NB_CHANNELS (CI),
        .OUTPUT_NB_CHANNELS(CO),
        .KERNEL_SIZE       (K),
        .NB_TILES          (NB)
    ) dut (
        .clk                    (clk),
        .arst_n_in              (arst_n_in),
        .start                  (start),
        .running                (running),
        .tile_req               (tile_req),
        .tile_idx               (tile_idx),
        .data_ready             (data_ready),
        .int_mem_re             (int_mem_re),
        .ky_out                 (ky_out),
        .kx_out                 (kx_out),
        .inch_out               (inch_out),
        .outch_out              (outch_out),
        .y_out                  (y_out),
        .x_out                  (x_out),
        .mac_valid              (mac_valid),
        .mac_accumulate_internal(mac_accumulate_internal),
        .mac_accumulate_with_0  (mac_accumulate_with_0),
        .mem_re                 (mem_re),
        .mem_read_addr          (mem_read_addr),
        .mem_we                 (mem_we),
        .mem_write_addr         (mem_write_addr),
        .output_valid           (output_valid),
        .output_ready           (output_ready),
        .output_x               (output_x),
        .output_y               (output_y),
        .output_ch              (output_ch),
        .tile_done              (tile_done),
        .fsm_done               (fsm_done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model state (monitor-owned except exp_load) ----------
    int n_mac, n_rd, n_out, n_we, n_re, n_load;
    int m_tile;
    int exp_load;
    int tiles_total = 0, fsm_total = 0, outs_total = 0;
    bit m_ov, prev_wr, prev_stall;
    longint s_ox, s_oy, s_och, s_ky, s_kx, s_ich, s_och_r, s_y, s_x;

    always @(negedge clk) begin
        bit stall_now, out_evt, wr_evt;
        int kh, kv, cho, chi, yy, xx, m;
        if (!arst_n_in) begin
            n_mac = 0; n_rd = 0; n_out = 0; n_we = 0; n_re = 0; n_load = 0;
            m_tile = 0; m_ov = 0; prev_wr = 0; prev_stall = 0;
        end else begin
            out_evt   = 0;
            wr_evt    = 0;
            stall_now = m_ov && !output_ready;

            check("output_valid", output_valid, m_ov);
            check("mem_we", mem_we, prev_wr);
            if (mem_we) begin
                check("mem_write_addr", mem_write_addr, n_we % CO);
                n_we++;
            end

            if (stall_now) begin
                check("stall_mac_valid", mac_valid, 0);
                check("stall_int_mem_re", int_mem_re, 0);
            end
            if (prev_stall) begin
                check("frz_output_x", output_x, s_ox);
                check("frz_output_y", output_y, s_oy);
                check("frz_output_ch", output_ch, s_och);
                check("frz_ky", ky_out, s_ky);
                check("frz_kx", kx_out, s_kx);
                check("frz_inch", inch_out, s_ich);
                check("frz_outch", outch_out, s_och_r);
                check("frz_y", y_out, s_y);
                check("frz_x", x_out, s_x);
            end

            if (output_valid && output_ready) begin
                m = n_out;
                check("output_x", output_x, m_tile * TW + m / (H * CO));
                check("output_y", output_y, (m / CO) % H);
                check("output_ch", output_ch, m % CO);
                n_out++;
                outs_total++;
            end

            if (mac_valid) begin
                kh  = n_mac % K;
                kv  = (n_mac / K) % K;
                cho = (n_mac / (K * K)) % CO;
                chi = (n_mac / (K * K * CO)) % CI;
                check("mac_after_read", n_mac < n_rd, 1);
                check("acc_internal", mac_accumulate_internal, !(kh == 0 && kv == 0));
                check("acc_with_0", mac_accumulate_with_0, kh == 0 && kv == 0 && chi == 0);
                check("mem_re", mem_re, kh == 0 && kv == 0 && chi != 0);
                check("mem_read_addr", mem_read_addr, cho);
                out_evt = (kh == K - 1) && (kv == K - 1) && (chi == CI - 1);
                wr_evt  = (kh == K - 1) && (kv == K - 1) && (chi != CI - 1);
                if (mem_re) n_re++;
                n_mac++;
            end else begin
                check("mem_re_idle", mem_re, 0);
            end

            if (int_mem_re) begin
                check("kx_out", kx_out, n_rd % K);
                check("ky_out", ky_out, (n_rd / K) % K);
                check("outch_out", outch_out, (n_rd / (K * K)) % CO);
                check("inch_out", inch_out, (n_rd / (K * K * CO)) % CI);
                yy = (n_rd / (K * K * CO * CI)) % H;
                xx = n_rd / (K * K * CO * CI * H);
                check("y_out", y_out, yy);
                check("x_out", x_out, xx);
                n_rd++;
            end

            if (tile_req) n_load++;
            if (running) check("tile_idx", tile_idx, m_tile);
            check("fsm_done", fsm_done, tile_done && (m_tile == NB - 1));

            if (tile_done) begin
                check("tile_macs", n_mac, 144);
                check("tile_reads", n_rd, 144);
                check("tile_outputs", n_out, 8);
                check("tile_psum_we", n_we, 8);
                check("tile_psum_re", n_re, 8);
                check("tile_load_cycles", n_load, exp_load);
                n_mac = 0; n_rd = 0; n_out = 0; n_we = 0; n_re = 0; n_load = 0;
                m_tile = (m_tile == NB - 1) ? 0 : m_tile + 1;
                tiles_total++;
                if (fsm_done) fsm_total++;
            end

            prev_wr    = wr_evt;
            m_ov       = out_evt || (m_ov && !output_ready);
            prev_stall = stall_now;
            s_ox = output_x; s_oy = output_y; s_och = output_ch;
            s_ky = ky_out; s_kx = kx_out; s_ich = inch_out; s_och_r = outch_out;
            s_y = y_out; s_x = x_out;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_layer();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    // Holds LOAD for exactly n cycles once tile_req appears.
    task automatic load_tile(input int n);
        int guard = 0;
        while (!tile_req && guard < 2000) begin
            @(posedge clk) #1;
            guard++;
        end
        check("tile_req_seen", tile_req, 1);
        exp_load = n;
        repeat (n - 1) @(posedge clk) #1;
        data_ready = 1'b1;
        @(posedge clk) #1 data_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (running && guard < 3000) begin
            @(posedge clk) #1;
            guard++;
        end
        check("idle_reached", running, 0);
    endtask

    task automatic run_layer(input int w0, input int w1);
        int t0, f0, o0;
        t0 = tiles_total; f0 = fsm_total; o0 = outs_total;
        start_layer();
        load_tile(w0);
        load_tile(w1);
        wait_idle();
        check("run_tile_done", tiles_total - t0, 2);
        check("run_fsm_done", fsm_total - f0, 1);
        check("run_outputs", outs_total - o0, 16);
    endtask

    task automatic stall_once();
        int guard = 0, quiet = 0;
        while (!output_valid && guard < 2000) begin
            @(posedge clk) #1;
            guard++;
        end
        check("first_output_seen", output_valid, 1);
        output_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!mac_valid && !int_mem_re) quiet++;
            @(posedge clk) #1;
        end
        output_ready = 1'b1;
        check("stall_quiet_cycles", quiet, 10);
    endtask

    task automatic noise_in_mac();
        int guard = 0;
        while (!mac_valid && guard < 2000) begin
            @(posedge clk) #1;
            guard++;
        end
        check("mac_seen", mac_valid, 1);
        start = 1'b1;
        data_ready = 1'b1;
        repeat (20) @(posedge clk) #1;
        start = 1'b0;
        data_ready = 1'b0;
        check("noise_tile_idx", tile_idx, 0);
        check("noise_running", running, 1);
        check("noise_no_req", tile_req, 0);
    endtask

    initial begin
        // reset state
        #3;
        check("rst_running", running, 0);
        check("rst_output_valid", output_valid, 0);
        check("rst_tile_idx", tile_idx, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_tile_req", tile_req, 0);
        check("rst_output_x", output_x, 0);
        @(posedge clk) #1 arst_n_in = 1'b1;

        // 1: reset in the middle of MAC, then clean restart
        start_layer();
        load_tile(2);
        repeat (20) @(posedge clk) #1;
        check("midmac_running", running, 1);
        arst_n_in = 1'b0;
        #2;
        check("abort_running", running, 0);
        check("abort_output_valid", output_valid, 0);
        check("abort_tile_idx", tile_idx, 0);
        check("abort_mac_valid", mac_valid, 0);
        check("abort_tile_done", tile_done, 0);
        @(posedge clk) #1 arst_n_in = 1'b1;

        // 2 + 3 + 5: full layer, first tile held in LOAD for 5 cycles
        run_layer(5, 3);

        // 4: back-pressure at the first output
        fork
            run_layer(4, 2);
            stall_once();
        join

        // 6: start and data_ready toggled while the nest is running
        fork
            run_layer(3, 6);
            noise_in_mac();
        join

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
